// File: rtl/pa_dtcm_pkg.sv
// Shared constants and types for the DTCM SRAM controller: state encoding,
// requester ids and the read-response tag.
package pa_dtcm_pkg;

  localparam int PA_ADDR_WIDTH = 11;
  localparam int PA_DATA_WIDTH = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_BUS = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rtag_t;

  // Active-low write-enable lane for one byte strobe.
  function automatic logic [7:0] lane_wen(input logic strb);
    return {8{~strb}};
  endfunction

endpackage

// File: rtl/pa_dtcm_sram_arb.sv
// Two-port fixed-priority arbiter with a starvation escape for the bus port.
// Grants are combinational; only the starvation counter is registered.
module pa_dtcm_sram_arb
  import pa_dtcm_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic cpuclk,
  input  logic cpurst_b,
  input  logic run,
  input  logic lsu_req,
  input  logic bus_req,
  output logic lsu_gnt,
  output logic bus_gnt
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_r;
  logic             starved_s;

  assign starved_s = (starve_cnt_r == CNT_MAX);

  // Same-cycle grant: LSU by default, bus when alone or when starved.
  always_comb begin
    lsu_gnt = 1'b0;
    bus_gnt = 1'b0;
    if (!run) begin
      lsu_gnt = 1'b0;
    end else if (bus_req && (!lsu_req || starved_s)) begin
      bus_gnt = 1'b1;
    end else if (lsu_req) begin
      lsu_gnt = 1'b1;
    end else begin
      lsu_gnt = 1'b0;
    end
  end

  // Count consecutive bus denials in RUN, saturating at STARVE_MAX.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      starve_cnt_r <= '0;
    end else if (!run || !bus_req || bus_gnt) begin
      starve_cnt_r <= '0;
    end else if (!starved_s) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/pa_dtcm_sram_ctrl.sv
// DTCM SRAM controller: optional zero-sweep after reset, then one arbitrated
// access per cycle to the single-port macro with a tagged one-cycle read return.
module pa_dtcm_sram_ctrl
  import pa_dtcm_pkg::*;
#(
  parameter int ADDR_WIDTH = PA_ADDR_WIDTH,
  parameter int DATA_WIDTH = PA_DATA_WIDTH,
  parameter int STARVE_MAX = 4,
  parameter int INIT_EN    = 1
) (
  input  logic                    cpuclk,
  input  logic                    cpurst_b,
  input  logic                    lsu_req,
  input  logic                    lsu_wr,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_bstrb,
  output logic                    lsu_gnt,
  output logic                    lsu_rvalid,
  input  logic                    bus_req,
  input  logic                    bus_wr,
  input  logic [ADDR_WIDTH-1:0]   bus_addr,
  input  logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH/8-1:0] bus_bstrb,
  output logic                    bus_gnt,
  output logic                    bus_rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   init_cnt_r;
  logic                    init_done_r;
  rtag_t                   rtag_r;

  logic                    run_s;
  logic                    sweep_s;
  logic                    sel_wr_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic [BE_WIDTH-1:0]     sel_bstrb_s;

  // Qualified by reset so the macro sees an idle interface while cpurst_b is low.
  assign run_s   = cpurst_b & (state_r == ST_RUN);
  assign sweep_s = cpurst_b & (state_r == ST_INIT);

  pa_dtcm_sram_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .cpuclk   (cpuclk),
    .cpurst_b (cpurst_b),
    .run      (run_s),
    .lsu_req  (lsu_req),
    .bus_req  (bus_req),
    .lsu_gnt  (lsu_gnt),
    .bus_gnt  (bus_gnt)
  );

  // Payload of whichever port holds the grant.
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_bstrb_s = '0;
    if (bus_gnt) begin
      sel_wr_s    = bus_wr;
      sel_addr_s  = bus_addr;
      sel_wdata_s = bus_wdata;
      sel_bstrb_s = bus_bstrb;
    end else if (lsu_gnt) begin
      sel_wr_s    = lsu_wr;
      sel_addr_s  = lsu_addr;
      sel_wdata_s = lsu_wdata;
      sel_bstrb_s = lsu_bstrb;
    end else begin
      sel_wr_s    = 1'b0;
    end
  end

  // Macro pin encoding; a zero-strobe write keeps GWEN low but masks every bit.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (sweep_s) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_r;
      sram_d    = '0;
    end else if (lsu_gnt || bus_gnt) begin
      sram_cen = 1'b0;
      sram_a   = sel_addr_s;
      sram_d   = sel_wdata_s;
      if (sel_wr_s) begin
        sram_gwen = 1'b0;
        for (int i = 0; i < BE_WIDTH; i++) begin
          sram_wen[8*i +: 8] = lane_wen(sel_bstrb_s[i]);
        end
      end else begin
        sram_gwen = 1'b1;
      end
    end else begin
      sram_cen = 1'b1;
    end
  end

  // Sweep FSM, init_done and the read-response tag.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_r     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_cnt_r  <= '0;
      init_done_r <= (INIT_EN != 0) ? 1'b0 : 1'b1;
      rtag_r      <= '0;
    end else begin
      rtag_r.valid <= (lsu_gnt & ~lsu_wr) | (bus_gnt & ~bus_wr);
      rtag_r.port  <= bus_gnt ? PORT_BUS : PORT_LSU;
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == LAST_ADDR) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            init_cnt_r  <= init_cnt_r + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          init_done_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  assign init_done  = init_done_r;
  assign lsu_rvalid = rtag_r.valid & (rtag_r.port == PORT_LSU);
  assign bus_rvalid = rtag_r.valid & (rtag_r.port == PORT_BUS);
  assign rdata      = sram_q;

endmodule

// File: doc/pa_dtcm_sram_ctrl.md
Name: pa_dtcm_sram_ctrl

Overview:
Controller and arbiter in front of the 2048x32 LSU single-port SRAM macro wrapper (active-low CEN/GWEN/WEN interface, Q valid one cycle after access).
- Shares the macro between two requesters: the LSU pipeline (port 0) and the AHB slave/debug path (port 1).
- After reset, optionally sweeps the whole array to zero before granting any traffic.
- Issues at most one SRAM access per cycle and returns read data one cycle later, tagged to the owning port.

Parameters:
ADDR_WIDTH, 11, word address width (array depth = 2^ADDR_WIDTH)
DATA_WIDTH, 32, data width; byte strobe width is DATA_WIDTH/8
STARVE_MAX, 4, consecutive port-1 denials before port 1 is forced to win one cycle
INIT_EN, 1, 1 = zero-sweep the array after reset; 0 = go straight to RUN

Ports:
cpuclk  in  1  clock
cpurst_b  in  1  asynchronous active-low reset
lsu_req  in  1  port-0 access request
lsu_wr  in  1  1 = write, 0 = read
lsu_addr  in  ADDR_WIDTH  word address
lsu_wdata  in  DATA_WIDTH  write data
lsu_bstrb  in  DATA_WIDTH/8  byte write strobes, active-high
lsu_gnt  out  1  port-0 request accepted this cycle
lsu_rvalid  out  1  port-0 read data valid
bus_req, bus_wr, bus_addr, bus_wdata, bus_bstrb  in  same as port 0  port-1 request
bus_gnt  out  1  port-1 request accepted this cycle
bus_rvalid  out  1  port-1 read data valid
rdata  out  DATA_WIDTH  read data; shared by both ports, qualified by *_rvalid
init_done  out  1  high once the zero-sweep has finished
sram_a  out  ADDR_WIDTH  to macro A
sram_cen  out  1  to macro CEN, active-low
sram_gwen  out  1  to macro GWEN, active-low
sram_wen  out  DATA_WIDTH  to macro WEN, active-low bit mask
sram_d  out  DATA_WIDTH  to macro D
sram_q  in  DATA_WIDTH  from macro Q

Behaviour:
- Clock and reset: single clock cpuclk; reset cpurst_b is asynchronous and active-low.
- Reset values:
  - gnt/rvalid outputs: 0.
  - init_done: 0 if INIT_EN=1, else 1.
  - Starvation counter: 0.
  - State: INIT if INIT_EN=1, else RUN.
  - SRAM outputs are driven combinationally from state; in reset they are cen=1, gwen=1, wen=all ones.
- FSM states: INIT, RUN.
- INIT:
  - 11-bit counter initialised to 0.
  - Each cycle drives cen=0, gwen=0, wen=0, d=0, a=counter, then increments the counter.
  - After the write at address 2^ADDR_WIDTH-1: transition to RUN and set init_done=1 next cycle.
  - Both gnt outputs stay 0 throughout; the counter must not wrap back to 0.
- RUN arbitration (combinational, same cycle):
  - Port 0 wins by default.
  - Port 1 wins if only bus_req is asserted, or if both requests are asserted and starve_cnt==STARVE_MAX.
  - Exactly one gnt is high when any request is present; none when idle.
  - Requesters hold req and payload stable until gnt.
- Starvation counter:
  - Increments when bus_req=1 and bus_gnt=0, saturating at STARVE_MAX.
  - Clears to 0 when bus_gnt=1 or bus_req=0.
- Access encoding for the granted port:
  - cen=0, a=addr, d=wdata.
  - Write: gwen=0; wen[8i+7:8i] = ~{8{bstrb[i]}}.
  - Write with bstrb=0: cen=0 and gwen=0 but wen is all ones, so no bits change.
  - Read: gwen=1, wen all ones.
  - No grant: cen=1, gwen=1, wen all ones.
- Read response:
  - One-cycle registered tag {valid, port}, set on a granted read.
  - Next cycle: rdata=sram_q and the matching *_rvalid=1 for exactly one cycle.
- Throughput: back-to-back reads from either port are accepted every cycle, with no bubble.
- Read after write to the same address in consecutive cycles returns the new data; the macro handles this, and the block adds no forwarding.
- Reset mid-INIT or mid-read: state returns to its reset value immediately; a pending rvalid is dropped and is never emitted after reset release.

Decomposition:
- Shared package pa_dtcm_pkg: ADDR_WIDTH/DATA_WIDTH constants, state encoding (INIT=1'b0, RUN=1'b1), port id constants (PORT_LSU=0, PORT_BUS=1).
- One natural sub-module, pa_dtcm_sram_arb: combinational grant plus starvation counter.
- FSM, SRAM encoding and response tag stay in the top-level module.

Test Plan:
- INIT sweep: release reset with INIT_EN=1 and both reqs held → 2048 zero-writes at a=0..2047, gnts 0 throughout; init_done rises on cycle 2049; then read 0x7FF → rdata=0.
- Write/readback: lsu write addr 0x010 data 0xDEADBEEF bstrb 4'hF, then bus write 0x010 data 0x11223344 bstrb 4'b0010, then lsu read 0x010 → rdata=0xDEAD33EF, lsu_rvalid only.
- Starvation with STARVE_MAX=4: both ports request continuously → lsu_gnt for 4 cycles, bus_gnt on the 5th cycle, then the pattern repeats.
- Pipelined reads: alternating lsu/bus reads each cycle at different addresses → one rvalid per cycle, tag matches the granted port of the previous cycle, no bubbles.
- Zero-strobe write: bstrb=0 write to 0x020 holding 0xA5A5A5A5 → wen all ones; a subsequent read returns 0xA5A5A5A5.
- Reset mid-operation: assert cpurst_b low on the cycle after a granted read and during INIT at counter 0x300 → no rvalid after release; INIT restarts at address 0.
